// File: rtl/fft_pkg.sv
// Shared types and width helpers for the FFT stage scheduler.
//   complex_16    : packed 16-bit re/im sample, used by the datapath around the scheduler
//   sched_state_e : scheduler FSM states
//   fft_aw        : address/stage width for an N-point transform
//   fft_cnt_w     : width of the drain down-counter for a given write-back latency
package fft_pkg;

   typedef struct packed {
      logic signed [15:0] re;
      logic signed [15:0] im;
   } complex_16;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      DONE
   } sched_state_e;

   function automatic int fft_aw(input int n);
      return $clog2(n);
   endfunction

   // Counter must hold LAT-1; keep at least one bit.
   function automatic int fft_cnt_w(input int lat);
      return (lat > 2) ? $clog2(lat) : 1;
   endfunction

endpackage

// File: rtl/fft_wb_delay.sv
// Write-back delay line: carries {valid, addr_a, addr_b} of each butterfly read
// forward by LAT cycles so the matching write lands when the butterfly result
// leaves the pipeline. All outputs come straight from flops.
// Ports:
//   clk        in   clock
//   clr_n      in   synchronous active-low clear (valids and addresses to 0)
//   rd_valid   in   a butterfly read is issued this cycle
//   rd_addr_a  in   A operand address of that read
//   rd_addr_b  in   B operand address of that read
//   wr_valid   out  write-back strobe, rd_valid delayed LAT cycles
//   wr_addr_a  out  rd_addr_a delayed LAT cycles
//   wr_addr_b  out  rd_addr_b delayed LAT cycles
module fft_wb_delay #(
   parameter int LAT = 2,
   parameter int AW  = 3
) (
   input  logic          clk,
   input  logic          clr_n,
   input  logic          rd_valid,
   input  logic [AW-1:0] rd_addr_a,
   input  logic [AW-1:0] rd_addr_b,
   output logic          wr_valid,
   output logic [AW-1:0] wr_addr_a,
   output logic [AW-1:0] wr_addr_b
);

   logic [LAT-1:0] vld_q;
   logic [AW-1:0]  a_q [LAT];
   logic [AW-1:0]  b_q [LAT];

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         vld_q <= '0;
         for (int i = 0; i < LAT; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
         end
      end else begin
         vld_q[0] <= rd_valid;
         a_q[0]   <= rd_addr_a;
         b_q[0]   <= rd_addr_b;
         for (int i = 1; i < LAT; i++) begin
            vld_q[i] <= vld_q[i-1];
            a_q[i]   <= a_q[i-1];
            b_q[i]   <= b_q[i-1];
         end
      end
   end

   assign wr_valid  = vld_q[LAT-1];
   assign wr_addr_a = a_q[LAT-1];
   assign wr_addr_b = b_q[LAT-1];

endmodule

// File: rtl/fft_stage_scheduler.sv
// Sequences an in-place radix-2 DIT FFT over a dual-port sample RAM and a
// pipelined 2-point butterfly. Each stage issues N/2 reads (one per cycle),
// the write-back addresses follow LAT cycles later through fft_wb_delay, and
// the pipeline is drained before the next stage starts so no read of stage
// s+1 can see a sample that stage s has not yet written.
//
// Optional feature macro: FFT_SCHED_HOLD_EN adds input `hold`, which stalls
// read issue while in ISSUE (in-flight writes still complete).
//
// Ports:
//   clk         in   clock
//   rst_n       in   synchronous active-low reset
//   start       in   begin a transform (sampled in IDLE only)
//   hold        in   stall issue in ISSUE (only with FFT_SCHED_HOLD_EN)
//   busy        out  transform in progress (ISSUE or DRAIN)
//   done        out  one-cycle pulse after the last write of the last stage
//   rd_en       out  butterfly read this cycle
//   rd_addr_a   out  A operand address
//   rd_addr_b   out  B operand address (A + span)
//   rd_addr_tw  out  twiddle ROM index
//   wr_en       out  butterfly write-back this cycle
//   wr_addr_a   out  A result address
//   wr_addr_b   out  B result address
//   stage       out  current stage 0..AW-1
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | one butterfly read per cycle, idx 0..N/2-1 of the current stage
// DRAIN | LAT cycles with no reads while the last writes of the stage retire
// DONE  | single cycle, done pulse, then back to IDLE
module fft_stage_scheduler
   import fft_pkg::*;
#(
   parameter int N   = 8,
   parameter int LAT = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
`ifdef FFT_SCHED_HOLD_EN
   input  logic                  hold,
`endif
   output logic                  busy,
   output logic                  done,
   output logic                  rd_en,
   output logic [fft_aw(N)-1:0]  rd_addr_a,
   output logic [fft_aw(N)-1:0]  rd_addr_b,
   output logic [fft_aw(N)-2:0]  rd_addr_tw,
   output logic                  wr_en,
   output logic [fft_aw(N)-1:0]  wr_addr_a,
   output logic [fft_aw(N)-1:0]  wr_addr_b,
   output logic [fft_aw(N)-1:0]  stage
);

   localparam int AW = fft_aw(N);
   localparam int DW = fft_cnt_w(LAT);
   localparam logic [AW-2:0] IDX_LAST   = (AW-1)'(N/2 - 1);
   localparam logic [AW-1:0] STAGE_LAST = AW'(AW - 1);
   localparam logic [DW-1:0] DRAIN_LOAD = DW'(LAT - 1);

   sched_state_e  state_q, state_d;
   logic [AW-2:0] idx_q, idx_d;
   logic [AW-1:0] stage_q, stage_d;
   logic [DW-1:0] drain_q, drain_d;
   logic          hold_i;
   logic          issue;

   logic [AW-1:0] idx_ext;
   logic [AW-1:0] span;
   logic [AW-1:0] k;
   logic [AW-1:0] g;
   logic [AW-1:0] addr_a;
   logic [AW-2:0] tw;

`ifdef FFT_SCHED_HOLD_EN
   assign hold_i = hold;
`else
   assign hold_i = 1'b0;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q   <= '0;
         stage_q <= '0;
         drain_q <= '0;
      end else begin
         idx_q   <= idx_d;
         stage_q <= stage_d;
         drain_q <= drain_d;
      end
   end

   // Next-state logic. DRAIN length is a down-counter loaded with LAT-1 on
   // the last issue, so the first read of the next stage lands exactly one
   // cycle after the last write of the current one.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      stage_d = stage_q;
      drain_d = drain_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ISSUE;
               idx_d   = '0;
               stage_d = '0;
            end
         end
         ISSUE: begin
            if (!hold_i) begin
               if (idx_q == IDX_LAST) begin
                  state_d = DRAIN;
                  idx_d   = '0;
                  drain_d = DRAIN_LOAD;
               end else begin
                  idx_d = idx_q + (AW-1)'(1);
               end
            end
         end
         DRAIN: begin
            if (drain_q == '0) begin
               if (stage_q == STAGE_LAST) begin
                  state_d = DONE;
               end else begin
                  state_d = ISSUE;
                  stage_d = stage_q + AW'(1);
               end
            end else begin
               drain_d = drain_q - DW'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
            stage_d = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   // Butterfly addressing for stage s: span = 2^s, the pair index is split
   // into group g (upper bits) and offset k (lower s bits); A inserts a 0 at
   // bit s, B sets it. Twiddle index scales k up to the full ROM range.
   always_comb begin
      idx_ext = {1'b0, idx_q};
      span    = AW'(1) << stage_q;
      k       = idx_ext & (span - AW'(1));
      g       = idx_ext >> stage_q;
      addr_a  = (g << (stage_q + AW'(1))) | k;
      tw      = (AW-1)'(k << (STAGE_LAST - stage_q));
   end

   // Outputs. Read addresses are forced to 0 when not issuing so idle and
   // reset cycles present clean zeros (and the delay line carries zeros).
   always_comb begin
      issue      = (state_q == ISSUE) && !hold_i;
      rd_en      = issue;
      busy       = (state_q == ISSUE) || (state_q == DRAIN);
      done       = (state_q == DONE);
      rd_addr_a  = '0;
      rd_addr_b  = '0;
      rd_addr_tw = '0;
      if (issue) begin
         rd_addr_a  = addr_a;
         rd_addr_b  = addr_a | span;
         rd_addr_tw = tw;
      end
   end

   assign stage = stage_q;

   fft_wb_delay #(
      .LAT (LAT),
      .AW  (AW)
   ) u_wb_delay (
      .clk       (clk),
      .clr_n     (rst_n),
      .rd_valid  (rd_en),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .wr_valid  (wr_en),
      .wr_addr_a (wr_addr_a),
      .wr_addr_b (wr_addr_b)
   );

endmodule
